imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator sitting between instruction fetch/decode and the execute-stage operand mux.
//  Takes an instruction word, an EXTOp code and a sideband tag over a valid/ready handshake.
//  Returns the XLEN-wide extended immediate one cycle later through a 2-entry skid buffer.
//  Adds to the single-cycle extender:
//   - XLEN 32/64;
//   - byte-aligned or legacy immediate format;
//   - CSR zimm and shamt formats;
//   - illegal-shamt flag;
//   - flush;
//   - backpressure.
// PARAMETERS
//  XLEN     32  immediate/output width; legal values 32 or 64
//  ALIGNED  1   1: SB/UJ are byte offsets (<<1) and U is <<12; 0: legacy unshifted format
//  TAG_W    8   width of sideband tag (PC index, rd, ...) carried alongside the immediate
// PORTS
//  clk        in   1      rising-edge clock
//  rstn       in   1      synchronous, active-low reset
//  flush      in   1      synchronous pipeline flush; drops every held entry
//  in_valid   in   1      instr/extop/in_tag valid
//  in_ready   out  1      block can accept this cycle
//  instr      in   32     instruction word
//  extop      in   3      format select (see BEHAVIOUR)
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      imm/out_tag/illegal valid
//  out_ready  in   1      consumer accepts this cycle
//  imm        out  XLEN   extended immediate
//  out_tag    out  TAG_W  tag of the entry
//  illegal    out  1      entry carries an illegal immediate
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//   - out_valid=0, in_ready=1, imm=0, out_tag=0, illegal=0; both entries empty.
//   - Reset overrides flush and any handshake in the same cycle, including mid-transfer.
//  Handshake:
//   - Transfer occurs when valid&&ready.
//   - While out_valid&&!out_ready, imm/out_tag/illegal stay stable.
//   - in_ready never depends combinationally on out_ready (registered: in_ready = !skid_valid).
//  Latency:
//   - 1 cycle from input transfer to out_valid when empty; throughput 1/cycle while out_ready=1.
//  Storage: main reg (drives outputs) + skid reg.
//   - Accept while main empty, or main draining same cycle: write main.
//   - Accept while main full and not draining: write skid, so in_ready=0 next cycle.
//   - Main drains with skid full: skid moves to main, skid empties.
//   - Order is strictly FIFO; no entry is lost or duplicated.
//  States by occupancy: EMPTY(0), ONE(main), TWO(main+skid).
//   - EMPTY->ONE on accept.
//   - ONE->TWO on accept&&!drain.
//   - ONE->EMPTY on drain&&!accept.
//   - TWO->ONE on drain.
//   - Simultaneous accept+drain in ONE stays ONE.
//  flush=1: next state EMPTY; any same-cycle input is dropped; in_ready=1 next cycle.
//  extop decode (s = instr[31], sign-extended to XLEN):
//   000 I:  sext(instr[31:20])
//   001 IU: zext(instr[31:20])
//   010 S:  sext({instr[31:25],instr[11:7]})
//   011 SB:
//    - ALIGNED=1: sext({s,instr[7],instr[30:25],instr[11:8],1'b0})
//    - ALIGNED=0: sext({s,instr[7],instr[30:25],instr[11:8]})
//   100 UJ:
//    - ALIGNED=1: sext({s,instr[19:12],instr[20],instr[30:21],1'b0})
//    - ALIGNED=0: sext({s,instr[19:12],instr[20],instr[30:21]})
//   101 U:
//    - ALIGNED=1: sext({instr[31:12],12'b0}) (XLEN=64 sign-extends bit31)
//    - ALIGNED=0: zext(instr[31:12])
//   110 Z:  zext(instr[19:15]) (CSR zimm)
//   111 SH:
//    - zext(instr[25:20]) when XLEN=64;
//    - zext(instr[24:20]) when XLEN=32, illegal=1 if instr[25]=1.
//  illegal is 0 for every other code.
//  Width rule: all extension targets XLEN; no intermediate truncation.
// STRUCTURE
//  Shared package ext_pkg:
//   - EXT_I..EXT_SH 3-bit localparams (existing 000-101 codes unchanged, 110/111 new);
//   - XLEN legality check helper.
//  Sub-module imm_decode: purely combinational (instr, extop) -> (imm, illegal), parametrised by XLEN/ALIGNED.
//  Top holds handshake, occupancy and the two entry registers.
// TESTING
//  1. XLEN=32: I, instr=0xFFF00093 -> imm=0xFFFFFFFF, out_valid 1 cycle after accept, illegal=0.
//  2. SB, instr=0xFE000EE3 (beq -4):
//   - ALIGNED=1 -> imm=0xFFFFFFFC;
//   - ALIGNED=0 -> imm=0xFFFFFFFE.
//  3. U, instr=0x123450B7:
//   - ALIGNED=1 -> 0x12345000;
//   - ALIGNED=0 -> 0x00012345;
//   - XLEN=64 with instr=0x800000B7, ALIGNED=1 -> 0xFFFFFFFF80000000.
//  4. SH, instr=0x02009093, XLEN=32 -> imm=0x00000000, illegal=1; same at XLEN=64 -> imm=0x20, illegal=0.
//  5. Backpressure: out_ready=0, send tags 1,2,3 back-to-back:
//   - in_ready=0 after 2 accepts, tag 3 held by source;
//   - out_ready=1 -> outputs tags 1,2,3 in order, none lost or duplicated.
//  6. Flush/reset: with 2 entries held:
//   - flush=1 with in_valid=1 -> out_valid=0, in_ready=1 next cycle, input dropped;
//   - repeat with rstn=0 -> all outputs 0.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared definitions for the immediate extender: format codes, occupancy
// states of the output skid buffer and the XLEN legality helper.
package ext_pkg;

  localparam logic [2:0] EXT_I  = 3'b000;
  localparam logic [2:0] EXT_IU = 3'b001;
  localparam logic [2:0] EXT_S  = 3'b010;
  localparam logic [2:0] EXT_SB = 3'b011;
  localparam logic [2:0] EXT_UJ = 3'b100;
  localparam logic [2:0] EXT_U  = 3'b101;
  localparam logic [2:0] EXT_Z  = 3'b110;
  localparam logic [2:0] EXT_SH = 3'b111;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: (instr, extop) -> XLEN-wide immediate
// plus the illegal-shamt flag. Every format is built at 64 bits, then sized.
module imm_decode
  import ext_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit ALIGNED = 1'b1
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_extop,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  logic        w_s;
  logic [63:0] w_imm64;
  logic        w_unused;

  assign w_s = i_instr[31];

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_imm64   = '0;
    o_illegal = 1'b0;
    case (i_extop)
      EXT_I:  w_imm64 = {{52{w_s}}, i_instr[31:20]};
      EXT_IU: w_imm64 = {52'b0, i_instr[31:20]};
      EXT_S:  w_imm64 = {{52{w_s}}, i_instr[31:25], i_instr[11:7]};
      EXT_SB: begin
        if (ALIGNED)
          w_imm64 = {{51{w_s}}, w_s, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        else
          w_imm64 = {{52{w_s}}, w_s, i_instr[7], i_instr[30:25], i_instr[11:8]};
      end
      EXT_UJ: begin
        if (ALIGNED)
          w_imm64 = {{43{w_s}}, w_s, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        else
          w_imm64 = {{44{w_s}}, w_s, i_instr[19:12], i_instr[20], i_instr[30:21]};
      end
      EXT_U: begin
        if (ALIGNED)
          w_imm64 = {{32{w_s}}, i_instr[31:12], 12'b0};
        else
          w_imm64 = {44'b0, i_instr[31:12]};
      end
      EXT_Z:  w_imm64 = {59'b0, i_instr[19:15]};
      EXT_SH: begin
        // RV32 shifts only take 5 bits; a set bit 25 is an out-of-range shamt.
        if (XLEN == 64) begin
          w_imm64 = {58'b0, i_instr[25:20]};
        end else begin
          w_imm64   = {59'b0, i_instr[24:20]};
          o_illegal = i_instr[25];
        end
      end
      default: w_imm64 = '0;
    endcase
  end

  assign o_imm = w_imm64[XLEN-1:0];

  // Opcode bits and the upper half at XLEN=32 are intentionally not used.
  assign w_unused = ^{i_instr[6:0], w_imm64};

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate generator: decodes on accept, holds results in a
// main + skid register pair so in_ready never depends on out_ready.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit ALIGNED = 1'b1,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       extop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  generate
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_ext_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  occ_e             r_state;
  occ_e             w_state_nxt;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  logic [XLEN-1:0]  w_dec_imm;
  logic             w_dec_ill;

  logic [XLEN-1:0]  r_main_imm;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_main_ill;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;

  imm_decode #(
    .XLEN    (XLEN),
    .ALIGNED (ALIGNED)
  ) u_decode (
    .i_instr   (instr),
    .i_extop   (extop),
    .o_imm     (w_dec_imm),
    .o_illegal (w_dec_ill)
  );

  // Both handshake outputs decode straight from the state register.
  assign in_ready  = (r_state != OCC_TWO);
  assign out_valid = (r_state != OCC_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_drain   = out_valid && out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = OCC_ONE;
            w_load_main = 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = OCC_TWO;
            w_load_skid = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (w_drain) begin
            w_state_nxt    = OCC_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_main_ill <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_imm <= w_dec_imm;
        r_main_tag <= in_tag;
        r_main_ill <= w_dec_ill;
      end else if (w_skid_to_main) begin
        r_main_imm <= r_skid_imm;
        r_main_tag <= r_skid_tag;
        r_main_ill <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_dec_imm;
        r_skid_tag <= in_tag;
        r_skid_ill <= w_dec_ill;
      end
    end
  end

  assign imm     = r_main_imm;
  assign out_tag = r_main_tag;
  assign illegal = r_main_ill;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench: four parameter variants share one input stream and
// are compared against a queue-based FIFO model and an arithmetic decoder.
module tb_imm_ext_pipe;
  import ext_pkg::*;

  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic [31:0]      instr;
  logic [2:0]       extop;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  // Instance order: 0 = XLEN32/aligned, 1 = XLEN32/legacy, 2 = XLEN64/aligned, 3 = XLEN64/legacy
  logic [3:0]       w_in_ready;
  logic [3:0]       w_out_valid;
  logic [3:0]       w_illegal;
  logic [TAG_W-1:0] w_out_tag [4];
  logic [31:0]      w_imm32a, w_imm32l;
  logic [63:0]      w_imm64a, w_imm64l;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0]      ins;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .ALIGNED(1'b1), .TAG_W(TAG_W)) u_dut32a (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready[0]),
    .instr(instr), .extop(extop), .in_tag(in_tag), .out_valid(w_out_valid[0]),
    .out_ready(out_ready), .imm(w_imm32a), .out_tag(w_out_tag[0]), .illegal(w_illegal[0]));

  imm_ext_pipe #(.XLEN(32), .ALIGNED(1'b0), .TAG_W(TAG_W)) u_dut32l (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready[1]),
    .instr(instr), .extop(extop), .in_tag(in_tag), .out_valid(w_out_valid[1]),
    .out_ready(out_ready), .imm(w_imm32l), .out_tag(w_out_tag[1]), .illegal(w_illegal[1]));

  imm_ext_pipe #(.XLEN(64), .ALIGNED(1'b1), .TAG_W(TAG_W)) u_dut64a (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready[2]),
    .instr(instr), .extop(extop), .in_tag(in_tag), .out_valid(w_out_valid[2]),
    .out_ready(out_ready), .imm(w_imm64a), .out_tag(w_out_tag[2]), .illegal(w_illegal[2]));

  imm_ext_pipe #(.XLEN(64), .ALIGNED(1'b0), .TAG_W(TAG_W)) u_dut64l (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready[3]),
    .instr(instr), .extop(extop), .in_tag(in_tag), .out_valid(w_out_valid[3]),
    .out_ready(out_ready), .imm(w_imm64l), .out_tag(w_out_tag[3]), .illegal(w_illegal[3]));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Immediate value as a signed integer, then wrapped to the target width.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] op,
                                          input int xlen, input bit aligned);
    longint      v;
    logic [11:0] f12;
    logic [19:0] f20;
    v = 0;
    case (op)
      EXT_I:  begin f12 = ins[31:20]; v = $signed(f12); end
      EXT_IU: v = longint'(ins[31:20]);
      EXT_S:  begin f12 = {ins[31:25], ins[11:7]}; v = $signed(f12); end
      EXT_SB: begin
        f12 = {ins[31], ins[7], ins[30:25], ins[11:8]};
        v = $signed(f12);
        if (aligned) v = v * 2;
      end
      EXT_UJ: begin
        f20 = {ins[31], ins[19:12], ins[20], ins[30:21]};
        v = $signed(f20);
        if (aligned) v = v * 2;
      end
      EXT_U: begin
        f20 = ins[31:12];
        if (aligned) v = longint'($signed(f20)) * 4096;
        else         v = longint'(f20);
      end
      EXT_Z:  v = longint'(ins[19:15]);
      default: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  function automatic logic ref_ill(input logic [31:0] ins, input logic [2:0] op, input int xlen);
    return (op == EXT_SH) && (xlen == 32) && ins[25];
  endfunction

  task automatic model_step();
    bit acc;
    bit drn;
    if (!rstn || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{ins: instr, op: extop, tag: in_tag});
    end
  endtask

  task automatic check_outputs();
    ent_t e;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("out_valid[%0d]", k), w_out_valid[k], q.size() > 0);
      check($sformatf("in_ready[%0d]", k), w_in_ready[k], q.size() < 2);
    end
    if (q.size() > 0) begin
      e = q[0];
      check("imm32a", {32'b0, w_imm32a}, ref_imm(e.ins, e.op, 32, 1'b1));
      check("imm32l", {32'b0, w_imm32l}, ref_imm(e.ins, e.op, 32, 1'b0));
      check("imm64a", w_imm64a, ref_imm(e.ins, e.op, 64, 1'b1));
      check("imm64l", w_imm64l, ref_imm(e.ins, e.op, 64, 1'b0));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_tag[%0d]", k), w_out_tag[k], e.tag);
        check($sformatf("illegal[%0d]", k), w_illegal[k], ref_ill(e.ins, e.op, (k < 2) ? 32 : 64));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_zero(input string name);
    check({name, "_imm32a"}, {32'b0, w_imm32a}, 64'h0);
    check({name, "_imm32l"}, {32'b0, w_imm32l}, 64'h0);
    check({name, "_imm64a"}, w_imm64a, 64'h0);
    check({name, "_imm64l"}, w_imm64l, 64'h0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_tag[%0d]", name, k), w_out_tag[k], 0);
      check($sformatf("%s_ill[%0d]", name, k), w_illegal[k], 0);
      check($sformatf("%s_valid[%0d]", name, k), w_out_valid[k], 0);
      check($sformatf("%s_ready[%0d]", name, k), w_in_ready[k], 1);
    end
  endtask

  // Single accepted transfer; caller guarantees in_ready is high.
  task automatic send(input logic [31:0] ins, input logic [2:0] op, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    instr    = ins;
    extop    = op;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [TAG_W-1:0] got_tags[$];
    bit               acc;

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; extop = '0; in_tag = '0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    check_reset_zero("reset");
    rstn = 1'b1;

    // I-type sign extension, one-cycle latency
    send(32'hFFF00093, EXT_I, 8'h11);
    check("t1_imm", {32'b0, w_imm32a}, 64'hFFFF_FFFF);
    check("t1_valid", w_out_valid[0], 1);
    check("t1_ill", w_illegal[0], 0);
    tick();

    send(32'hFE000EE3, EXT_SB, 8'h12);
    check("t2_sb_aligned", {32'b0, w_imm32a}, 64'hFFFF_FFFC);
    check("t2_sb_legacy", {32'b0, w_imm32l}, 64'hFFFF_FFFE);
    tick();

    send(32'h123450B7, EXT_U, 8'h13);
    check("t3_u_aligned", {32'b0, w_imm32a}, 64'h1234_5000);
    check("t3_u_legacy", {32'b0, w_imm32l}, 64'h0001_2345);
    tick();
    send(32'h800000B7, EXT_U, 8'h14);
    check("t3_u64_aligned", w_imm64a, 64'hFFFF_FFFF_8000_0000);
    tick();

    send(32'h02009093, EXT_SH, 8'h15);
    check("t4_sh32_imm", {32'b0, w_imm32a}, 64'h0);
    check("t4_sh32_ill", w_illegal[0], 1);
    check("t4_sh64_imm", w_imm64a, 64'h20);
    check("t4_sh64_ill", w_illegal[2], 0);
    tick();

    // Backpressure: third source word must wait, then all drain in order
    out_ready = 1'b0;
    send(32'h00100093, EXT_I, 8'd1);
    send(32'h00200093, EXT_I, 8'd2);
    check("t5_in_ready_full", w_in_ready[0], 0);
    in_valid = 1'b1; instr = 32'h00300093; extop = EXT_I; in_tag = 8'd3;
    tick();
    check("t5_hold_tag", w_out_tag[0], 8'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (w_out_valid[0]) got_tags.push_back(w_out_tag[0]);
      acc = in_valid && w_in_ready[0];
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("t5_count", got_tags.size(), 3);
    for (int i = 0; i < got_tags.size() && i < 3; i++)
      check($sformatf("t5_order[%0d]", i), got_tags[i], i + 1);

    // Flush with two entries held drops everything, including the new input
    out_ready = 1'b0;
    send(32'h00400093, EXT_I, 8'd4);
    send(32'h00500093, EXT_I, 8'd5);
    flush = 1'b1; in_valid = 1'b1; in_tag = 8'd6;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t6_flush_valid", w_out_valid[0], 0);
    check("t6_flush_ready", w_in_ready[0], 1);
    out_ready = 1'b1;
    tick();
    check("t6_flush_dropped", w_out_valid[0], 0);

    // Reset with two entries held overrides flush and handshake
    out_ready = 1'b0;
    send(32'h00700093, EXT_S, 8'd7);
    send(32'h00800093, EXT_UJ, 8'd8);
    rstn = 1'b0; flush = 1'b1; in_valid = 1'b1;
    tick();
    check_reset_zero("t6_reset");
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0;

    // Randomized traffic against the FIFO model
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 3);
      rstn      = !($urandom_range(199) == 0);
      instr     = $urandom;
      extop     = 3'($urandom_range(7));
      in_tag    = TAG_W'($urandom);
      tick();
    end
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
